// File: rtl/stis4_inv_r2_if.sv
// Streaming handshake bundle for the shared inverse S-box: one input channel, one output channel.
interface stis4_inv_r2_if;
  logic [7:0] in_share;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_share;
  logic       out_valid;
  logic       out_ready;

  modport slave (
    input  in_share,
    input  in_valid,
    input  out_ready,
    output in_ready,
    output out_share,
    output out_valid
  );

  modport master (
    output in_share,
    output in_valid,
    output out_ready,
    input  in_ready,
    input  out_share,
    input  out_valid
  );
endinterface

// File: rtl/stis4_inv_r2.sv
// Two-share, two-stage threshold implementation of the inverse PRESENT S-box.
// Optional build macro REMASK_EN adds the rnd port and refreshes the linear stage-1 shares.
module stis4_inv_r2 (
  input  logic           clk,
  input  logic           rst_n,
`ifdef REMASK_EN
  input  logic [3:0]     rnd,
`endif
  stis4_inv_r2_if.slave  bus
);

  // Shared AND of x_i and x_j: bit 0 is share A, bit 1 is share B; each term
  // pairs a share of bit i with one share of bit j, so x_i never appears unmasked.
  function automatic logic [1:0] shared_and(input logic a_i, input logic b_i,
                                            input logic a_j, input logic b_j);
    logic sh_a;
    logic sh_b;
    sh_a = (a_i & a_j) ^ (a_i & b_j);
    sh_b = (b_i & b_j) ^ (b_i & a_j);
    return {sh_b, sh_a};
  endfunction

  logic       en;
  logic [3:0] in_a;
  logic [3:0] in_b;

  logic [3:0] s1_la_d;
  logic [3:0] s1_lb_d;
  logic [5:0] s1_qa_d;
  logic [5:0] s1_qb_d;

  logic [3:0] s1_la;
  logic [3:0] s1_lb;
  logic [5:0] s1_qa;
  logic [5:0] s1_qb;
  logic       s1_valid;

  logic [1:0] c012;
  logic [1:0] c013;
  logic [1:0] c023;
  logic [3:0] ya;
  logic [3:0] yb;

  logic [7:0] out_share_q;
  logic       out_valid_q;

  assign in_a = bus.in_share[3:0];
  assign in_b = bus.in_share[7:4];

  assign en            = ~out_valid_q | bus.out_ready;
  assign bus.in_ready  = en;
  assign bus.out_share = out_share_q;
  assign bus.out_valid = out_valid_q;

`ifdef REMASK_EN
  assign s1_la_d = in_a ^ rnd;
  assign s1_lb_d = in_b ^ rnd;
`else
  assign s1_la_d = in_a;
  assign s1_lb_d = in_b;
`endif

  // Quadratic monomials, index order: 01, 02, 03, 12, 13, 23.
  always_comb begin
    s1_qa_d = '0;
    s1_qb_d = '0;
    {s1_qb_d[0], s1_qa_d[0]} = shared_and(in_a[0], in_b[0], in_a[1], in_b[1]);
    {s1_qb_d[1], s1_qa_d[1]} = shared_and(in_a[0], in_b[0], in_a[2], in_b[2]);
    {s1_qb_d[2], s1_qa_d[2]} = shared_and(in_a[0], in_b[0], in_a[3], in_b[3]);
    {s1_qb_d[3], s1_qa_d[3]} = shared_and(in_a[1], in_b[1], in_a[2], in_b[2]);
    {s1_qb_d[4], s1_qa_d[4]} = shared_and(in_a[1], in_b[1], in_a[3], in_b[3]);
    {s1_qb_d[5], s1_qa_d[5]} = shared_and(in_a[2], in_b[2], in_a[3], in_b[3]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_la    <= '0;
      s1_lb    <= '0;
      s1_qa    <= '0;
      s1_qb    <= '0;
      s1_valid <= 1'b0;
    end else if (en) begin
      s1_la    <= s1_la_d;
      s1_lb    <= s1_lb_d;
      s1_qa    <= s1_qa_d;
      s1_qb    <= s1_qb_d;
      s1_valid <= bus.in_valid;
    end
  end

  // Cubic terms x0x1x2, x0x1x3, x0x2x3 built as (quadratic register) * (linear register).
  always_comb begin
    c012 = shared_and(s1_qa[0], s1_qb[0], s1_la[2], s1_lb[2]);
    c013 = shared_and(s1_qa[0], s1_qb[0], s1_la[3], s1_lb[3]);
    c023 = shared_and(s1_qa[5], s1_qb[5], s1_la[0], s1_lb[0]);
  end

  // Algebraic normal form of INV, evaluated share-wise; the constant 1s ride on share A.
  always_comb begin
    ya = '0;
    yb = '0;
    ya[0] = ~(s1_la[0] ^ s1_la[2] ^ s1_qa[4]);
    yb[0] =   s1_lb[0] ^ s1_lb[2] ^ s1_qb[4];
    ya[1] = s1_la[0] ^ s1_la[1] ^ s1_la[3] ^ s1_qa[1] ^ s1_qa[4] ^ s1_qa[5]
          ^ c012[0] ^ c013[0] ^ c023[0];
    yb[1] = s1_lb[0] ^ s1_lb[1] ^ s1_lb[3] ^ s1_qb[1] ^ s1_qb[4] ^ s1_qb[5]
          ^ c012[1] ^ c013[1] ^ c023[1];
    ya[2] = ~(s1_la[3] ^ s1_qa[0] ^ s1_qa[1] ^ s1_qa[2] ^ s1_qa[3] ^ s1_qa[4]
          ^ c012[0] ^ c013[0] ^ c023[0]);
    yb[2] =   s1_lb[3] ^ s1_qb[0] ^ s1_qb[1] ^ s1_qb[2] ^ s1_qb[3] ^ s1_qb[4]
          ^ c012[1] ^ c013[1] ^ c023[1];
    ya[3] = s1_la[0] ^ s1_la[1] ^ s1_la[2] ^ s1_la[3] ^ s1_qa[0]
          ^ c012[0] ^ c023[0];
    yb[3] = s1_lb[0] ^ s1_lb[1] ^ s1_lb[2] ^ s1_lb[3] ^ s1_qb[0]
          ^ c012[1] ^ c023[1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_share_q <= 8'h00;
      out_valid_q <= 1'b0;
    end else if (en) begin
      out_share_q <= {yb, ya};
      out_valid_q <= s1_valid;
    end
  end

endmodule

// File: tb/tb_stis4_inv_r2.sv
// Scoreboard bench for stis4_inv_r2: expected inputs queued on acceptance, unmasked results checked on delivery.
module tb_stis4_inv_r2;

  logic clk;
  logic rst_n;
`ifdef REMASK_EN
  logic [3:0] rnd;
`endif

  stis4_inv_r2_if bus ();

  stis4_inv_r2 dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef REMASK_EN
    .rnd   (rnd),
`endif
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] inv_tab [16] = '{4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
                               4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA};

  int total = 0;
  int bad   = 0;
  logic [7:0] sb_q [$];

  function automatic logic [3:0] unmask(input logic [7:0] s);
    return s[3:0] ^ s[7:4];
  endfunction

  function automatic logic [3:0] model_inv(input logic [7:0] s);
    logic [3:0] x;
    x = s[3:0] ^ s[7:4];
    return inv_tab[x];
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_share = 8'h00;
    bus.out_ready = 1'b0;
`ifdef REMASK_EN
    rnd = 4'h0;
`endif
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid got=%b required=0", bus.out_valid); end
    total++;
    if (bus.out_share !== 8'h00) begin bad++; $display("[TB] FAIL reset_out_share got=%h required=00", bus.out_share); end
    total++;
    if (bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready got=%b required=1", bus.in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL post_reset_idle in_ready=%b out_valid=%b required 1/0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_first();
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_share = 8'h00;
    bus.out_ready = 1'b1;
    #1;
    total++;
    if (bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL first_in_ready got=%b required=1", bus.in_ready); end
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    total++;
    if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL first_latency1 out_valid got=%b required=0", bus.out_valid); end
    @(negedge clk);
    #1;
    total++;
    if (bus.out_valid !== 1'b1) begin bad++; $display("[TB] FAIL first_latency2 out_valid got=%b required=1", bus.out_valid); end
    total++;
    if (unmask(bus.out_share) !== 4'h5) begin bad++; $display("[TB] FAIL first_value got=%h required=5", unmask(bus.out_share)); end
    @(negedge clk);
    #1;
    total++;
    if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL first_no_dup out_valid got=%b required=0", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    int rx;
    logic [7:0] exp_in;
    rx = 0;
    for (int cyc = 0; cyc < 266; cyc++) begin
      @(negedge clk);
      bus.in_valid = (cyc < 256);
      bus.in_share = 8'(cyc);
      bus.out_ready = 1'b1;
      #1;
      if (cyc < 256) begin
        total++;
        if (bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL b2b_in_ready cyc=%0d got=%b required=1", cyc, bus.in_ready); end
      end
      if (bus.in_valid && bus.in_ready) sb_q.push_back(bus.in_share);
      if (bus.out_valid && bus.out_ready) begin
        total++;
        if (sb_q.size() == 0) begin
          bad++; $display("[TB] FAIL b2b_unexpected got=%h required=none", unmask(bus.out_share));
        end else begin
          exp_in = sb_q.pop_front();
          rx++;
          if (unmask(bus.out_share) !== model_inv(exp_in)) begin
            bad++; $display("[TB] FAIL b2b_value in=%h got=%h required=%h", exp_in, unmask(bus.out_share), model_inv(exp_in));
          end
        end
      end
    end
    total++;
    if (rx !== 256 || sb_q.size() != 0) begin
      bad++; $display("[TB] FAIL b2b_count got=%0d required=256 left=%0d", rx, sb_q.size());
    end
  endtask

  task automatic test_stall();
    int rx;
    logic [7:0] exp_in;
    rx = 0;
    for (int cyc = 0; cyc < 14; cyc++) begin
      @(negedge clk);
      bus.in_valid  = (cyc < 7);
      bus.in_share  = (cyc == 0) ? 8'hA7 : (cyc == 1) ? 8'h1C : 8'hFF;
      bus.out_ready = (cyc >= 7);
      #1;
      if (cyc >= 2 && cyc <= 6) begin
        total++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
          bad++; $display("[TB] FAIL stall_hold cyc=%0d in_ready=%b out_valid=%b required 0/1", cyc, bus.in_ready, bus.out_valid);
        end
        total++;
        if (unmask(bus.out_share) !== model_inv(8'hA7)) begin
          bad++; $display("[TB] FAIL stall_value cyc=%0d got=%h required=%h", cyc, unmask(bus.out_share), model_inv(8'hA7));
        end
      end
      if (bus.in_valid && bus.in_ready) sb_q.push_back(bus.in_share);
      if (bus.out_valid && bus.out_ready) begin
        total++;
        if (sb_q.size() == 0) begin
          bad++; $display("[TB] FAIL stall_unexpected got=%h required=none", unmask(bus.out_share));
        end else begin
          exp_in = sb_q.pop_front();
          rx++;
          if (unmask(bus.out_share) !== model_inv(exp_in)) begin
            bad++; $display("[TB] FAIL stall_order in=%h got=%h required=%h", exp_in, unmask(bus.out_share), model_inv(exp_in));
          end
        end
      end
    end
    total++;
    if (rx !== 2 || sb_q.size() != 0) begin
      bad++; $display("[TB] FAIL stall_count got=%0d required=2 left=%0d", rx, sb_q.size());
    end
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_share = 8'h3C; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_share = 8'h96;
    @(negedge clk);
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    total++;
    if (bus.out_valid !== 1'b0 || bus.out_share !== 8'h00) begin
      bad++; $display("[TB] FAIL midreset_clear out_valid=%b out_share=%h required 0/00", bus.out_valid, bus.out_share);
    end
    total++;
    if (bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL midreset_in_ready got=%b required=1", bus.in_ready); end
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      #1;
      total++;
      if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL midreset_stale cyc=%0d out_valid=%b required=0", cyc, bus.out_valid); end
    end
    sb_q.delete();
  endtask

  task automatic test_random();
    int acc;
    int rx;
    logic [7:0] exp_in;
    acc = 0;
    rx = 0;
    for (int cyc = 0; cyc < 10030; cyc++) begin
      @(negedge clk);
      bus.in_valid  = (cyc < 10000) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.in_share  = 8'($urandom);
      bus.out_ready = (cyc < 10000) ? ($urandom_range(0, 3) != 0) : 1'b1;
`ifdef REMASK_EN
      rnd = 4'($urandom);
`endif
      #1;
      if (bus.in_valid && bus.in_ready) begin sb_q.push_back(bus.in_share); acc++; end
      if (bus.out_valid && bus.out_ready) begin
        total++;
        if (sb_q.size() == 0) begin
          bad++; $display("[TB] FAIL rand_unexpected got=%h required=none", unmask(bus.out_share));
        end else begin
          exp_in = sb_q.pop_front();
          rx++;
          if (unmask(bus.out_share) !== model_inv(exp_in)) begin
            bad++; $display("[TB] FAIL rand_value in=%h got=%h required=%h", exp_in, unmask(bus.out_share), model_inv(exp_in));
          end
        end
      end
    end
    total++;
    if (acc == 0 || rx !== acc || sb_q.size() != 0) begin
      bad++; $display("[TB] FAIL rand_drain got=%0d required=%0d left=%0d", rx, acc, sb_q.size());
    end
  endtask

`ifdef REMASK_EN
  task automatic test_remask();
    logic [7:0] seen [$];
    int distinct;
    bit found;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      bus.in_valid  = (cyc < 16);
      bus.in_share  = 8'h50;
      bus.out_ready = 1'b1;
      rnd = 4'(cyc);
      #1;
      if (bus.out_valid && bus.out_ready) begin
        total++;
        if (unmask(bus.out_share) !== 4'h1) begin
          bad++; $display("[TB] FAIL remask_value got=%h required=1", unmask(bus.out_share));
        end
        seen.push_back(bus.out_share);
      end
    end
    distinct = 0;
    for (int i = 0; i < seen.size(); i++) begin
      found = 1'b0;
      for (int j = 0; j < i; j++) if (seen[j] == seen[i]) found = 1'b1;
      if (!found) distinct++;
    end
    total++;
    if (seen.size() != 16 || distinct < 2) begin
      bad++; $display("[TB] FAIL remask_vary outputs=%0d distinct=%0d required 16/>1", seen.size(), distinct);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_first();
    test_back_to_back();
    test_stall();
    test_reset_midflight();
`ifdef REMASK_EN
    test_remask();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stis4_inv_r2.md
STIS4_INV_R2 -- requirements
Module: stis4_inv_r2

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-003 SHALL have port in_share, input, 8: shared 4-bit S-box output; share A = in_share[3:0], share B = in_share[7:4].
REQ-004 SHALL have port in_valid, input, 1: in_share valid this cycle.
REQ-005 SHALL have port in_ready, output, 1: block accepts in_share this cycle.
REQ-006 SHALL have port out_share, output, 8: shared inverse S-box result; share A = [3:0], share B = [7:4].
REQ-007 SHALL have port out_valid, output, 1: out_share valid.
REQ-008 SHALL have port out_ready, input, 1: consumer accepts out_share.
REQ-009 SHALL have port rnd, input, 4: fresh remask randomness; present only when REMASK_EN is defined.

Function
REQ-010 SHALL compute unmasked result y = INV[x], where x = share A ^ share B and INV = {5,E,F,8,C,1,2,D,B,4,6,3,0,7,9,A} (index 0..F): the inverse of S-box C56B90AD3EF84712.
REQ-011 SHALL implement INV as a two-stage threshold implementation: stage 1 uses only quadratic-or-lower component functions of the input shares, with outputs registered; stage 2 uses only quadratic-or-lower component functions of the stage-1 registers, with outputs registered.
REQ-012 SHALL make no stage-1 component function depend on both share A and share B of the same input bit in any single product term (non-completeness).
REQ-013 SHALL never form x or y unmasked in any wire or register.
REQ-014 SHALL use a single pipeline enable: en = !out_valid | out_ready; in_ready = en.
REQ-015 SHALL load the stage-1 registers and s1_valid = in_valid when en; otherwise all stage-1 state holds.
REQ-016 SHALL load the stage-2 registers, out_share and out_valid = s1_valid, when en; otherwise all stage-2 state holds.
REQ-017 SHALL have a latency of exactly 2 cycles from accepted input (in_valid & in_ready) to out_valid, when not stalled.
REQ-018 SHALL sustain a throughput of 1 result per cycle while out_ready = 1.
REQ-019 SHALL keep out_share and out_valid stable while out_valid = 1 and out_ready = 0, with no input accepted.
REQ-020 SHALL deliver results in acceptance order, with no loss or duplication, under any in_valid/out_ready pattern.
REQ-021 SHALL, when a stage is empty (valid bit 0), still clock its data registers from their inputs; data with valid bit 0 is don't-care.

Reset
REQ-022 SHALL clear s1_valid and out_valid to 0 when rst_n = 0 at a rising edge.
REQ-023 SHALL clear all share registers and out_share to 8'h00 when rst_n = 0 at a rising edge.
REQ-024 SHALL discard in-flight data on reset asserted mid-operation; no out_valid occurs for it after release.
REQ-025 SHALL hold in_ready = 1 during and after reset, since out_valid = 0.

Configuration
REQ-026 SHALL, when REMASK_EN is defined, add port rnd and XOR rnd into both stage-1 share registers for the bits of one 4-bit intermediate, leaving the unmasked value unchanged; rnd is sampled only when en = 1.
REQ-027 SHALL, when REMASK_EN is undefined, omit port rnd and all remask logic; out_share SHALL then be a pure function of in_share.

Verification
REQ-028 SHALL cover: after reset, accept in_share = 8'h00 with out_ready = 1 -> out_valid = 1 two cycles later and share A ^ share B = 5.
REQ-029 SHALL cover: all 256 in_share values streamed back-to-back with out_ready = 1 -> 256 outputs in order, each unmasking to INV[A^B] (e.g. 8'h3F -> C^... i.e. x = C -> y = 0).
REQ-030 SHALL cover: out_ready = 0 for 5 cycles with 2 items in flight -> in_ready = 0, out_share stable, both items delivered in order after release.
REQ-031 SHALL cover: rst_n = 0 for 1 cycle with items in both stages -> out_valid = 0 next cycle; out_share = 8'h00; no stale output afterwards.
REQ-032 SHALL cover: with REMASK_EN, in_share = 8'h50 with rnd swept over 0..F -> out_share varies but always unmasks to INV[5] = 1.
REQ-033 SHALL cover: random in_valid/out_ready toggling over 10,000 cycles -> scoreboard match and no deadlock.
